// File: rtl/mem_ls_pkg.sv
// Shared encodings for the memory-stage load/store sequencer and the
// WB load-extension stage.
package mem_ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] READBE_WORD = 3'b000;
  localparam logic [2:0] READBE_LBU  = 3'b001;
  localparam logic [2:0] READBE_LB   = 3'b010;
  localparam logic [2:0] READBE_LHU  = 3'b011;
  localparam logic [2:0] READBE_LH   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } ls_state_e;

  // Size code 3 falls through to the word encoding.
  function automatic logic [2:0] readbe_code(input logic [1:0] size, input logic sign);
    logic [2:0] code;
    case (size)
      SZ_BYTE: code = sign ? READBE_LB : READBE_LBU;
      SZ_HALF: code = sign ? READBE_LH : READBE_LHU;
      default: code = READBE_WORD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Combinational byte-enable, store-lane replication and alignment check
// for a single load/store access.
module mem_be_gen
  import mem_ls_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be         = 4'b0001 << i_addr_lo;
        o_wdata      = {4{i_wdata[7:0]}};
        o_misaligned = 1'b0;
      end
      SZ_HALF: begin
        o_be         = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_ls_ctrl.sv
// Memory-stage load/store sequencer: checks alignment, drives a handshaked
// data bus, stalls the pipeline until completion and returns raw load data.
module mem_ls_ctrl
  import mem_ls_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              ld_valid,
  output logic [31:0]       ld_rdata,
  output logic [1:0]        ld_a,
  output logic [2:0]        ld_readbe,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  ls_state_e         r_state;
  ls_state_e         w_next_state;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_misaligned;
  logic              w_accept;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;
  logic              r_ld_valid;
  logic [31:0]       r_ld_rdata;
  logic [1:0]        r_ld_a;
  logic [2:0]        r_ld_readbe;
  logic [1:0]        r_pend_a;
  logic [2:0]        r_pend_readbe;

  mem_be_gen u_be_gen (
    .i_size       (req_size),
    .i_addr_lo    (req_addr[1:0]),
    .i_wdata      (req_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  assign w_accept = (r_state == IDLE) && req_valid && !w_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_accept ? BUS : IDLE;
      BUS:     w_next_state = bus_ready ? RESP : BUS;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    exc_adel = 1'b0;
    exc_ades = 1'b0;
    case (r_state)
      IDLE: begin
        stall    = w_accept;
        exc_adel = req_valid && w_misaligned && !req_we;
        exc_ades = req_valid && w_misaligned && req_we;
      end
      BUS:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Load tags are parked at issue and only published when the load
  // completes, so a store in flight never disturbs the last load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_be      <= 4'b0000;
      r_bus_wdata   <= 32'h0000_0000;
      r_ld_valid    <= 1'b0;
      r_ld_rdata    <= 32'h0000_0000;
      r_ld_a        <= 2'b00;
      r_ld_readbe   <= 3'b000;
      r_pend_a      <= 2'b00;
      r_pend_readbe <= 3'b000;
    end else begin
      r_ld_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bus_req     <= 1'b1;
            r_bus_we      <= req_we;
            r_bus_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
            r_bus_be      <= w_be;
            r_bus_wdata   <= w_wdata;
            r_pend_a      <= req_addr[1:0];
            r_pend_readbe <= readbe_code(req_size, req_sign);
          end
        end
        BUS: begin
          if (bus_ready) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
              r_ld_valid  <= 1'b1;
              r_ld_rdata  <= bus_rdata;
              r_ld_a      <= r_pend_a;
              r_ld_readbe <= r_pend_readbe;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign ld_valid  = r_ld_valid;
  assign ld_rdata  = r_ld_rdata;
  assign ld_a      = r_ld_a;
  assign ld_readbe = r_ld_readbe;

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// Self-checking bench for mem_ls_ctrl: directed plan scenarios followed by
// random accesses checked against an access-level reference model.
module tb_mem_ls_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        exc_adel;
  logic        exc_ades;
  logic        ld_valid;
  logic [31:0] ld_rdata;
  logic [1:0]  ld_a;
  logic [2:0]  ld_readbe;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  // Reference state: last completed load as the pipeline should see it.
  logic [31:0] m_rdata;
  logic [1:0]  m_a;
  logic [2:0]  m_readbe;

  always #5 clk = ~clk;

  mem_ls_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .ld_valid(ld_valid), .ld_rdata(ld_rdata), .ld_a(ld_a), .ld_readbe(ld_readbe),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int mask = (1 << n) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    if (n == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [2:0] model_readbe(input logic [1:0] sz, input logic sg);
    int n = nbytes(sz);
    if (n == 4) return 3'd0;
    return 3'((n == 1 ? 1 : 3) + (sg ? 1 : 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ld_model(input string tag);
    check({tag, "_ld_rdata"}, ld_rdata, m_rdata);
    check({tag, "_ld_a"}, 32'(ld_a), 32'(m_a));
    check({tag, "_ld_readbe"}, 32'(ld_readbe), 32'(m_readbe));
  endtask

  // Aligned access: one IDLE cycle, waits+1 BUS cycles, then RESP.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd);
    int stalls = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
    req_addr = addr; req_wdata = wd; bus_ready = 1'b0;
    #1;
    if (stall) stalls++;
    check({tag, "_exc_idle"}, {30'd0, exc_adel, exc_ades}, 32'd0);
    tick();
    check({tag, "_bus_req"}, 32'(bus_req), 32'd1);
    check({tag, "_bus_we"}, 32'(bus_we), 32'(we));
    check({tag, "_bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
    check({tag, "_bus_be"}, 32'(bus_be), 32'(model_be(sz, addr)));
    if (we) check({tag, "_bus_wdata"}, bus_wdata, model_wdata(sz, wd));
    for (int k = 0; k <= waits; k++) begin
      bus_ready = (k == waits);
      bus_rdata = rd;
      #1;
      if (stall) stalls++;
      if (k == waits) check({tag, "_bus_held"}, {bus_req, bus_addr[30:0]}, {1'b1, addr[30:2], 2'b00});
      tick();
    end
    if (!we) begin
      m_rdata = rd; m_a = addr[1:0]; m_readbe = model_readbe(sz, sg);
    end
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 2));
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_resp_ld_valid"}, 32'(ld_valid), 32'(!we));
    check_ld_model({tag, "_resp"});
    tick();
    req_valid = 1'b0;
    bus_ready = 1'b0;
    #1;
    check({tag, "_idle_ld_valid"}, 32'(ld_valid), 32'd0);
    check({tag, "_idle_stall"}, 32'(stall), 32'd0);
    check_ld_model({tag, "_idle"});
  endtask

  task automatic do_mis(input string tag, input logic we, input logic [1:0] sz,
                        input logic [31:0] addr);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = 1'b0;
    req_addr = addr; req_wdata = $urandom; bus_ready = 1'b0;
    #1;
    check({tag, "_exc_adel"}, 32'(exc_adel), 32'(!we));
    check({tag, "_exc_ades"}, 32'(exc_ades), 32'(we));
    check({tag, "_stall"}, 32'(stall), 32'd0);
    tick();
    check({tag, "_no_bus"}, 32'(bus_req), 32'd0);
    req_valid = 1'b0;
    #1;
    check({tag, "_exc_clear"}, {30'd0, exc_adel, exc_ades}, 32'd0);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_ctl"}, {26'd0, stall, exc_adel, exc_ades, ld_valid, bus_req, bus_we}, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_be_ld"}, {23'd0, bus_be, ld_a, ld_readbe}, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_ld_rdata"}, ld_rdata, 32'd0);
  endtask

  initial begin
    logic        r_we;
    logic [1:0]  r_sz;
    logic        r_sg;
    logic [31:0] r_addr;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_sign = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    m_rdata = 32'd0; m_a = 2'd0; m_readbe = 3'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_all_reset("reset");

    do_txn("lb_1003", 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 32'h80AA_BBCC);
    check("lb_readbe_val", 32'(ld_readbe), 32'b010);
    do_txn("sh_2002", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 3, 32'd0);
    do_mis("lw_3001", 1'b0, 2'd2, 32'h0000_3001);
    do_mis("sh_3001", 1'b1, 2'd1, 32'h0000_3001);

    // lhu abandoned by reset in its second BUS cycle
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_sign = 1'b0;
    req_addr = 32'h0000_4000; bus_ready = 1'b0;
    tick();
    check("lhu_bus1", 32'(bus_req), 32'd1);
    tick();
    check("lhu_bus2_stall", 32'(stall), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0;
    m_rdata = 32'd0; m_a = 2'd0; m_readbe = 3'd0;
    #1;
    check_all_reset("mid_bus_reset");
    tick();
    check("post_reset_idle", 32'(bus_req), 32'd0);
    do_txn("lw_4004", 1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'd0, 1, 32'hDEAD_BEEF);

    do_txn("b2b_lw", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 0, 32'h0102_0304);
    do_txn("b2b_sb", 1'b1, 2'd0, 1'b0, 32'h0000_0015, 32'h0000_007F, 0, 32'd0);
    check("b2b_sb_wdata", bus_wdata, 32'h7F7F_7F7F);
    check("b2b_sb_be", 32'(bus_be), 32'b0010);

    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_sg   = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if (model_mis(r_sz, r_addr))
        do_mis($sformatf("rnd%0d_mis", i), r_we, r_sz, r_addr);
      else
        do_txn($sformatf("rnd%0d", i), r_we, r_sz, r_sg, r_addr, $urandom,
               int'($urandom_range(0, 3)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ls_ctrl.md
Name: mem_ls_ctrl

Overview:
- Memory-stage load/store sequencer between the MEM pipeline register and a handshaked data-memory bus.
- Checks alignment and generates byte enables and lane-replicated store data.
- Holds the pipeline (stall) until the bus completes.
- For loads, delivers the raw 32-bit word with the byte offset and the 3-bit extension code used by the WB load-extension stage.

Parameters:
ADDR_W, 32, byte-address width of req_addr/bus_addr

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage holds a load/store this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
req_sign  in  1  load sign-extend (ignored for word/store)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  freeze PC/IF/ID/EX/MEM this cycle
exc_adel  out  1  misaligned load, this cycle
exc_ades  out  1  misaligned store, this cycle
ld_valid  out  1  load result valid (one cycle)
ld_rdata  out  32  raw word from bus, unshifted
ld_a  out  2  req_addr[1:0] of completed load
ld_readbe  out  3  000 word, 001 lbu, 010 lb, 011 lhu, 100 lh
bus_req  out  1  transaction request
bus_we  out  1  write
bus_addr  out  ADDR_W  word-aligned address ([1:0]=0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated write data
bus_ready  in  1  slave accepts/completes in this cycle
bus_rdata  in  32  read data, valid when bus_ready && !bus_we

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high.
- On reset:
  - state=IDLE.
  - bus_req, bus_we, ld_valid = 0.
  - bus_addr, bus_be, bus_wdata, ld_rdata, ld_a, ld_readbe = 0.
  - stall, exc_* = 0.
- Alignment:
  - A half access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]!=0.
  - A byte access is never misaligned.
- FSM states:
  - IDLE:
    - req_valid and misaligned → exc_adel (load) or exc_ades (store) asserted combinationally. stall=0, no bus transaction, stay IDLE.
    - req_valid and aligned → stall=1 combinationally. At the clock edge, latch bus_addr={addr[ADDR_W-1:2],2'b00}, bus_we, bus_be, bus_wdata, ld_a, ld_readbe; set bus_req=1; go to BUS.
  - BUS:
    - stall=1; bus_* held constant.
    - On bus_ready: bus_req←0. For a load, ld_rdata←bus_rdata. Go to RESP.
    - bus_ready may be asserted in the first BUS cycle, giving minimum latency of 2 stall cycles.
  - RESP:
    - stall=0; ld_valid=1 for loads only. Pipeline advances at the end of this cycle.
    - req_valid is ignored in RESP; the old request is still visible.
    - Next cycle → IDLE; ld_valid←0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - Loads use the same enables.
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- ld_readbe:
  - word → 000
  - byte: sign=0 → 001, sign=1 → 010
  - half: sign=0 → 011, sign=1 → 100
- ld_a, ld_readbe, ld_rdata hold their values until the next load completes.
- Reset mid-BUS: return to IDLE and drop bus_req at that edge. The transaction is abandoned; the slave must tolerate the withdrawal.
- bus_ready seen in IDLE or RESP is ignored.
- No timeout; BUS waits indefinitely.

Decomposition:
- Package mem_ls_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - READBE_* codes (000..100), shared with the WB load-extension stage
  - state encoding IDLE/BUS/RESP
- Sub-module mem_be_gen (combinational) takes size, addr[1:0] and wdata, and produces be, lane-replicated wdata and misaligned.

Test Plan:
- lb, addr=0x1003, slave ready on 1st BUS cycle, rdata=0x80AABBCC:
  - bus_addr=0x1000, be=1000, stall high exactly 2 cycles.
  - RESP cycle: ld_valid=1, ld_a=3, ld_readbe=010, ld_rdata=0x80AABBCC.
- sh, addr=0x2002, wdata=0x1234ABCD, ready after 3 wait cycles:
  - bus_we=1, be=1100, bus_wdata=0xABCDABCD.
  - stall 5 cycles, ld_valid stays 0.
- lw addr=0x3001 → exc_adel=1 same cycle, stall=0, bus_req never rises.
- sh addr=0x3001 → exc_ades=1, no bus transaction.
- lhu addr=0x4000, reset asserted in 2nd BUS cycle:
  - next cycle state=IDLE, bus_req=0, all outputs at reset values.
  - A subsequent lw addr=0x4004 completes normally.
- Back-to-back lw 0x10 then sb 0x15 (wdata 0x7F), ready immediately:
  - second request starts the cycle after RESP.
  - sb: be=0010, bus_wdata=0x7F7F7F7F.
  - ld_* from the lw persist through the store.
